// File: rtl/sevenseg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan_driver
//  Purpose  : Time-multiplexed driver for a 4-digit common-anode seven-segment
//             display. Four 4-bit hex digits are written through a select/
//             write port and scanned onto one shared active-low segment bus,
//             one digit per slot, with an optional all-anodes-off gap between
//             slots to suppress ghosting.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//     REFRESH_DIV   clock cycles each digit is lit (>= 1)
//     BLANK_CYCLES  clock cycles of all-anodes-off between slots (>= 0)
//  Ports
//     clk         in   1  system clock, rising edge
//     rst         in   1  synchronous active-high reset
//     wr_en       in   1  write strobe for the digit store
//     wr_sel      in   2  digit index to write (0 = rightmost, an[0])
//     wr_data     in   4  hex value to store
//     digit_off   in   4  per-digit anode mask (1 = keep anode dark)
//     dp_in       in   4  per-digit decimal point request (1 = lit)
//     seg         out  7  {A,B,C,D,E,F,G}, active-low
//     dp          out  1  decimal point, active-low
//     an          out  4  anodes, active-low, at most one low
//     frame_tick  out  1  one-cycle pulse after digit 3's lit slot
// ============================================================================
module sevenseg_scan_driver #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [1:0] wr_sel,
   input  logic [3:0] wr_data,
   input  logic [3:0] digit_off,
   input  logic [3:0] dp_in,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       frame_tick
);

   // ------------------------------------------------------------------------
   // Counter sizing: one counter serves both the lit slot and the gap, so it
   // must hold the larger of the two terminal values.
   // ------------------------------------------------------------------------
   localparam int CNT_MAX  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int BLANK_M1 = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_M1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic             HAS_GAP    = (BLANK_CYCLES > 0);

   // FSM encoding
   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   // Idle output values (everything dark)
   localparam logic [3:0] AN_OFF  = 4'b1111;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]       state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       digit_q [4];
   logic [3:0]       digit_d [4];

   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;
   logic             frame_tick_q, frame_tick_d;

   // ------------------------------------------------------------------------
   // Hex to active-low segment pattern, bit order {A,B,C,D,E,F,G}.
   // ------------------------------------------------------------------------
   function automatic logic [6:0] decode_hex(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // ------------------------------------------------------------------------
   // Digit store. Writes land on the clock edge; the display path reads the
   // stored copy, so a write shows on seg one cycle after its edge.
   // ------------------------------------------------------------------------
   always_comb begin
      digit_d = digit_q;
      if (wr_en) begin
         digit_d[wr_sel] = wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Scan FSM: BLANK gap, then SHOW slot for digit idx, then advance idx.
   // The gap is skipped entirely when BLANK_CYCLES is zero; the reset BLANK
   // state then lasts a single cycle before the first slot.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q + CNT_ONE;
      frame_tick_d = 1'b0;

      case (state_q)
         ST_BLANK: begin
            if (!HAS_GAP || (cnt_q == BLANK_LAST)) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
            end
         end
         default: begin
            if (cnt_q == SHOW_LAST) begin
               idx_d        = idx_q + 2'd1;
               cnt_d        = '0;
               frame_tick_d = (idx_q == 2'd3);
               state_d      = HAS_GAP ? ST_BLANK : ST_SHOW;
            end
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output registers are loaded from the next-state view so that the pins
   // change on the same edge as the FSM itself. A masked digit keeps its
   // anode dark but still drives its decoded pattern on seg.
   // ------------------------------------------------------------------------
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state_d == ST_SHOW) begin
         an_d[idx_d] = digit_off[idx_d];
         seg_d       = decode_hex(digit_q[idx_d]);
         dp_d        = ~dp_in[idx_d];
      end
   end

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_BLANK;
         idx_q        <= 2'd0;
         cnt_q        <= '0;
         digit_q      <= '{default: 4'h0};
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         digit_q      <= digit_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sevenseg_scan_driver
//  Purpose  : Self-checking bench for sevenseg_scan_driver. Two instances run
//             side by side on the same stimulus: one with a 2-cycle gap and
//             one with no gap. A timeline model derives every output from the
//             number of cycles since reset release.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sevenseg_scan_driver;

   localparam int R = 4;
   localparam int B = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [1:0] wr_sel;
   logic [3:0] wr_data;
   logic [3:0] digit_off;
   logic [3:0] dp_in;

   logic [6:0] seg,  seg0;
   logic       dp,   dp0;
   logic [3:0] an,   an0;
   logic       ft,   ft0;

   always #5 clk = ~clk;

   sevenseg_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .digit_off(digit_off), .dp_in(dp_in),
      .seg(seg), .dp(dp), .an(an), .frame_tick(ft)
   );

   sevenseg_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .digit_off(digit_off), .dp_in(dp_in),
      .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   function automatic logic [6:0] dec(input logic [3:0] v);
      logic a, b, c, d, e, f, g;
      a = v inside {4'h1, 4'h4, 4'hB, 4'hD};
      b = v inside {4'h5, 4'h6, 4'hB, 4'hC, 4'hE, 4'hF};
      c = v inside {4'h2, 4'hC, 4'hE, 4'hF};
      d = v inside {4'h1, 4'h4, 4'h7, 4'hA, 4'hF};
      e = v inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9};
      f = v inside {4'h1, 4'h2, 4'h3, 4'h7, 4'hD};
      g = v inside {4'h0, 4'h1, 4'h7, 4'hC};
      return {a, b, c, d, e, f, g};
   endfunction

   logic [3:0] mdig [4];
   int         p = 0;
   bit         model_ok = 1'b0;
   logic [12:0] exp2, exp0;   // {frame_tick, dp, an[3:0], seg[6:0]}

   // p = cycles elapsed since the last reset edge. The post-reset gap lasts
   // max(gap,1) cycles, then slots of R lit + gap dark repeat with period
   // R+gap. The tick sits on the cycle after digit 3's lit slot.
   function automatic logic [12:0] model_out(input int pp, input int gap,
                                             input logic [3:0] doff, input logic [3:0] dpi);
      int l0, per, q, ix, w;
      logic [3:0] a;
      logic [6:0] s;
      logic d, t;
      l0  = (gap > 0) ? gap : 1;
      per = R + gap;
      a = 4'hF; s = 7'h7F; d = 1'b1; t = 1'b0;
      if (pp >= l0) begin
         q  = pp - l0;
         ix = (q / per) % 4;
         w  = q % per;
         t  = (q > 0) && (((q + gap) % (4 * per)) == 0);
         if (w < R) begin
            a[ix] = doff[ix];
            s     = dec(mdig[ix]);
            d     = ~dpi[ix];
         end
      end
      return {t, d, a, s};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         p = 0;
         for (int i = 0; i < 4; i++) mdig[i] = 4'h0;
         model_ok = 1'b1;
      end else begin
         p = p + 1;
      end
      exp2 = model_out(p, B, digit_off, dp_in);
      exp0 = model_out(p, 0, digit_off, dp_in);
      if (!rst && wr_en) mdig[wr_sel] = wr_data;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("an",    32'(an),   32'(exp2[10:7]));
         check("seg",   32'(seg),  32'(exp2[6:0]));
         check("dp",    32'(dp),   32'(exp2[11]));
         check("tick",  32'(ft),   32'(exp2[12]));
         check("an0",   32'(an0),  32'(exp0[10:7]));
         check("seg0",  32'(seg0), 32'(exp0[6:0]));
         check("dp0",   32'(dp0),  32'(exp0[11]));
         check("tick0", 32'(ft0),  32'(exp0[12]));
      end
   end

   // ------------------------------------------------------------------------
   // Directed helpers
   // ------------------------------------------------------------------------
   task automatic wait_an(input logic [3:0] v);
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (an == v) begin ok = 1'b1; break; end
      end
      if (!ok) check("wait_an_timeout", 32'(an), 32'(v));
   endtask

   task automatic wait_ft(input bit gapless);
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((gapless ? ft0 : ft) == 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) check("wait_tick_timeout", 32'(0), 32'(1));
   endtask

   task automatic do_reset();
      int n, len;
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", 32'({ft, dp, an, seg}), 32'(13'h0FFF));
      end
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (an == 4'b1110) break;
      end
      check("first_slot_delay", 32'(n), 32'(2));
      len = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (an != 4'b1110) break;
         len++;
      end
      check("first_slot_len", 32'(len), 32'(4));
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg_tab [4] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};

   initial begin
      int blanks, dplow, n, hold;
      rst = 1'b1; wr_en = 1'b0; wr_sel = 2'd0; wr_data = 4'h0;
      digit_off = 4'h0; dp_in = 4'h0;
      @(negedge clk);

      // Reset from power-up
      do_reset();

      // Scan order with digits 1,2,3,4
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_sel = 2'(i); wr_data = 4'(i + 1);
         @(negedge clk);
      end
      wr_en = 1'b0;
      wait_ft(1'b0);
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (c == 2 || c == 8 || c == 14 || c == 20) begin
            check("scan_an",  32'(an),  32'(an_tab[(c - 2) / 6]));
            check("scan_seg", 32'(seg), 32'(seg_tab[(c - 2) / 6]));
         end
         if (c == 7)  check("scan_gap", 32'(an), 32'(4'b1111));
         if (c == 24) check("frame_period", 32'(ft), 32'(1));
      end

      // Live write into the digit currently lit
      wait_an(4'b1011);
      wr_en = 1'b1; wr_sel = 2'd2; wr_data = 4'hA;
      @(negedge clk);
      wr_en = 1'b0;
      check("live_old_seg", 32'(seg), 32'(7'b0000110));
      @(negedge clk);
      check("live_new_seg", 32'(seg), 32'(7'b0001000));
      check("live_an",      32'(an),  32'(4'b1011));
      @(negedge clk);
      check("live_an_4th",  32'(an),  32'(4'b1011));
      @(negedge clk);
      check("live_slot_end", 32'(an), 32'(4'b1111));

      // Mask and decimal point
      digit_off = 4'b0100; dp_in = 4'b0001;
      wait_ft(1'b0);
      blanks = 0; dplow = 0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (an == 4'b1111) blanks++;
         if (dp == 1'b0) begin
            dplow++;
            check("dp_slot0_only", 32'(an), 32'(4'b1110));
         end
      end
      check("mask_dark_cycles", 32'(blanks), 32'(12));
      check("dp_low_cycles",    32'(dplow),  32'(4));
      check("mask_frame_tick",  32'(ft),     32'(1));
      digit_off = 4'h0; dp_in = 4'h0;

      // Reset in the middle of operation
      do_reset();

      // Decode sweep through digit 0
      for (int v = 0; v < 16; v++) begin
         wr_en = 1'b1; wr_sel = 2'd0; wr_data = 4'(v);
         @(negedge clk);
         wr_en = 1'b0;
         @(negedge clk);
         wait_an(4'b1110);
         if (v == 8)  check("dec_8", 32'(seg), 32'(7'b0000000));
         if (v == 12) check("dec_C", 32'(seg), 32'(7'b0110001));
         if (v == 11) check("dec_b", 32'(seg), 32'(7'b1100000));
      end

      // Gapless instance: 16-cycle frame with no dark cycles
      wait_ft(1'b1);
      n = 0; blanks = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (an0 == 4'b1111) blanks++;
         if (ft0) break;
      end
      check("gapless_period", 32'(n),      32'(16));
      check("gapless_dark",   32'(blanks), 32'(0));

      // Randomized traffic with occasional resets
      hold = 0;
      for (int k = 0; k < 2500; k++) begin
         if (hold > 0) begin
            rst = 1'b1; hold--;
         end else if ($urandom_range(0, 249) == 0) begin
            rst = 1'b1; hold = int'($urandom_range(0, 2));
         end else begin
            rst = 1'b0;
         end
         wr_en     = ($urandom_range(0, 2) == 0);
         wr_sel    = 2'($urandom_range(0, 3));
         wr_data   = 4'($urandom_range(0, 15));
         digit_off = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         dp_in     = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      rst = 1'b0; wr_en = 1'b0;
      repeat (30) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
